// File: rtl/dff_shift_ctrl.sv
// Serialiser that feeds a single-bit flop datapath: accepts a parallel word on a
// valid/ready handshake and presents it one bit per clock. Optional parity: DFF_SHIFT_CTRL_PARITY_EN.
module dff_shift_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef DFF_SHIFT_CTRL_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2, S_PAR = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               d_out_q, d_out_d;
    logic               d_valid_q, d_valid_d;
    logic               done_q, done_d;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic               last_bit;
    assign last_bit = (cnt_q == CNT_W'(WIDTH));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            d_out_q   <= 1'b0;
            d_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            done_q    <= done_d;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_valid) state_d = S_SHIFT;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
            S_SHIFT: if (last_bit) state_d = S_PAR;
            S_PAR:   state_d = S_DONE;
`else
            S_SHIFT: if (last_bit) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered-output and datapath next values; the register holds the not-yet-sent bits
    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        d_out_d   = 1'b0;
        d_valid_d = 1'b0;
        done_d    = 1'b0;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    d_valid_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                    if (LSB_FIRST) begin
                        d_out_d = data_in[0];
                        shreg_d = data_in >> 1;
                    end else begin
                        d_out_d = data_in[WIDTH-1];
                        shreg_d = data_in << 1;
                    end
`ifdef DFF_SHIFT_CTRL_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    d_valid_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (LSB_FIRST) begin
                        d_out_d = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end else begin
                        d_out_d = shreg_q[WIDTH-1];
                        shreg_d = shreg_q << 1;
                    end
                end else begin
                    cnt_d = '0;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
                    d_out_d   = parity_q;
                    d_valid_d = 1'b1;
`else
                    done_d    = 1'b1;
`endif
                end
            end
`ifdef DFF_SHIFT_CTRL_PARITY_EN
            S_PAR: done_d = 1'b1;
`endif
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign d_out       = d_out_q;
    assign d_valid     = d_valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_dff_shift_ctrl.sv
// Scoreboard bench for dff_shift_ctrl: LSB-first and MSB-first instances share the stimulus.
module tb_dff_shift_ctrl;

    localparam int unsigned W = 8;
`ifdef DFF_SHIFT_CTRL_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         sr_l, do_l, dv_l, busy_l, done_l;
    logic         sr_m, do_m, dv_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -100;
    logic prev_done = 1'b0;

    logic q_l[$];
    logic q_m[$];
    int   qd_l[$];
    int   qd_m[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dff_shift_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr_l),
        .data_in(data_in), .d_out(do_l), .d_valid(dv_l), .busy(busy_l), .done(done_l)
    );

    dff_shift_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr_m),
        .data_in(data_in), .d_out(do_m), .d_valid(dv_m), .busy(busy_m), .done(done_m)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard whenever a DUT shows a live bit or a done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) check("ready_after_done", int'(sr_l), 1);
            prev_done <= done_l;
            if (dv_l) begin
                if (q_l.size() == 0) check("lsb_extra_bit", 1, 0);
                else check("lsb_bit", int'(do_l), int'(q_l.pop_front()));
            end
            if (dv_m) begin
                if (q_m.size() == 0) check("msb_extra_bit", 1, 0);
                else check("msb_bit", int'(do_m), int'(q_m.pop_front()));
            end
            if (done_l) begin
                check("lsb_done_outs", int'({dv_l, do_l, sr_l, busy_l}), 1);
                if (qd_l.size() == 0) check("lsb_unexpected_done", 1, 0);
                else check("lsb_done_cycle", cyc, qd_l.pop_front());
                last_done = cyc;
            end
            if (done_m) begin
                if (qd_m.size() == 0) check("msb_unexpected_done", 1, 0);
                else check("msb_done_cycle", cyc, qd_m.pop_front());
            end
        end
    end

    // Called with inputs stable (between edges); returns #1 after the accept edge
    task automatic send(input logic [W-1:0] w, input bit drop_valid, output int acc);
        int n = 0;
        data_in = w;
        start_valid = 1'b1;
        while (!(sr_l && sr_m) && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (n >= 100) begin
            check("accept_timeout", 1, 0);
            return;
        end
        for (int i = 0; i < int'(W); i++) begin
            q_l.push_back(w[i]);
            q_m.push_back(w[W-1-i]);
        end
        if (P != 0) begin
            q_l.push_back(^w);
            q_m.push_back(^w);
        end
        qd_l.push_back(cyc + 1 + int'(W) + int'(P));
        qd_m.push_back(cyc + 1 + int'(W) + int'(P));
        @(posedge clk);
        #1;
        acc = cyc;
        if (drop_valid) start_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q_l.size() != 0 || q_m.size() != 0 || qd_l.size() != 0 ||
                qd_m.size() != 0 || busy_l || busy_m) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(n >= 200), 0);
    endtask

    initial begin
        int acc, rel, first_done;
        logic [W-1:0] pats [4];
        pats[0] = 8'h07; pats[1] = 8'h03; pats[2] = 8'hA5; pats[3] = 8'h80;

        // Reset held with start_valid high
        data_in = 8'hC2;
        #12;
        check("rst_ready",  int'(sr_l), 1);
        check("rst_valid",  int'(dv_l | dv_m), 0);
        check("rst_busy",   int'(busy_l | busy_m), 0);
        check("rst_done",   int'(done_l | done_m), 0);
        check("rst_dout",   int'(do_l | do_m), 0);

        // Release with start_valid high: accept on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        send(8'hC2, 1'b1, acc);
        check("release_accept_cycle", acc, rel + 1);
        check("busy_after_accept", int'(busy_l), 1);
        check("ready_low_busy", int'(sr_l), 0);
        wait_idle();

        // Held start_valid while data_in changes mid-transfer, then back-to-back accept
        @(negedge clk);
        send(8'hC2, 1'b0, acc);
        data_in = 8'hFF;
        first_done = acc + int'(W) + int'(P);
        send(8'hFF, 1'b1, acc);
        check("b2b_done_seen", last_done, first_done);
        check("b2b_accept_cycle", acc, first_done + 2);
        wait_idle();

        // Misc patterns, including parity cases 0x07 and 0x03
        foreach (pats[k]) begin
            @(negedge clk);
            send(pats[k], 1'b1, acc);
            wait_idle();
        end

        // Asynchronous reset after the 4th valid bit aborts without done
        @(negedge clk);
        send(8'hC2, 1'b1, acc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", int'(dv_l | dv_m), 0);
        check("abort_busy",  int'(busy_l | busy_m), 0);
        check("abort_ready", int'(sr_l & sr_m), 1);
        check("abort_done",  int'(done_l | done_m), 0);
        check("abort_bits_left", q_l.size(), int'(W) + int'(P) - 4);
        q_l.delete(); q_m.delete(); qd_l.delete(); qd_m.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", int'(busy_l | dv_l | done_l), 0);
        send(8'hC2, 1'b1, acc);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
